instr_fetch_decode: RTL and testbench

Single-clock instruction fetch and decode stage that sits directly upstream of the 4-stage register/ALU/writeback/store pipeline. It holds a 256-entry program memory, steps a program counter, splits each 24-bit instruction into the `func`, `rd`, `rs1`, `rs2` and `addr` fields the pipeline consumes, and handles jumps and halt. The pipeline has no forwarding, so this stage also detects read-after-write hazards against the last two issued instructions and inserts bubbles.

---
 rtl/instr_fetch_decode.sv | 115 +++++++++++
 tb/tb_instr_fetch_decode.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: program memory, PC sequencing and field decode with RAW stall insertion
module instr_fetch_decode #(
    parameter int IMEM_DEPTH = 256,
    parameter int IW = 24
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          start,
    input  logic          prog_we,
    input  logic [7:0]    prog_addr,
    input  logic [IW-1:0] prog_data,
    output logic [3:0]    func,
    output logic [3:0]    rd,
    output logic [3:0]    rs1,
    output logic [3:0]    rs2,
    output logic [7:0]    addr,
    output logic          issue_valid,
    output logic [7:0]    pc,
    output logic          halted
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    localparam logic [3:0] F_JMP  = 4'd13;
    localparam logic [3:0] F_HALT = 4'd14;

    state_t        r_state;
    logic [IW-1:0] r_mem [IMEM_DEPTH];
    logic [7:0]    r_pc;
    logic [3:0]    r_func, r_rd, r_rs1, r_rs2;
    logic [7:0]    r_addr;
    logic          r_issue_valid, r_halted;
    logic          r_h0_v, r_h1_v;
    logic [3:0]    r_h0_rd, r_h1_rd;

    logic [IW-1:0] w_instr;
    logic [3:0]    w_func, w_rd, w_rs1, w_rs2;
    logic [7:0]    w_addr;
    logic          w_alu, w_hit, w_stall, w_issue;

    assign w_instr = r_mem[r_pc];
    assign w_func  = w_instr[23:20];
    assign w_rd    = w_instr[19:16];
    assign w_rs1   = w_instr[15:12];
    assign w_rs2   = w_instr[11:8];
    assign w_addr  = w_instr[7:0];
    assign w_alu   = w_func < 4'd12;
    assign w_hit   = (r_h0_v && (w_rs1 == r_h0_rd || w_rs2 == r_h0_rd)) ||
                     (r_h1_v && (w_rs1 == r_h1_rd || w_rs2 == r_h1_rd));
    assign w_stall = w_alu && w_hit;
    assign w_issue = w_alu && !w_hit;

    assign func        = r_func;
    assign rd          = r_rd;
    assign rs1         = r_rs1;
    assign rs2         = r_rs2;
    assign addr        = r_addr;
    assign issue_valid = r_issue_valid;
    assign pc          = r_pc;
    assign halted      = r_halted;

    // program loading is locked out while instructions are being fetched
    always_ff @(posedge clk1) begin
        if (prog_we && r_state != S_RUN)
            r_mem[prog_addr] <= prog_data;
    end

    // sequencing, hazard history and registered decode outputs
    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= 8'd0;
            r_func        <= 4'd0;
            r_rd          <= 4'd0;
            r_rs1         <= 4'd0;
            r_rs2         <= 4'd0;
            r_addr        <= 8'd0;
            r_issue_valid <= 1'b0;
            r_halted      <= 1'b0;
            r_h0_v        <= 1'b0;
            r_h1_v        <= 1'b0;
            r_h0_rd       <= 4'd0;
            r_h1_rd       <= 4'd0;
        end else if (r_state != S_RUN) begin
            r_issue_valid <= 1'b0;
            if (start) begin
                r_state  <= S_RUN;
                r_pc     <= 8'd0;
                r_halted <= 1'b0;
                r_h0_v   <= 1'b0;
                r_h1_v   <= 1'b0;
            end
        end else begin
            r_h1_v        <= r_h0_v;
            r_h1_rd       <= r_h0_rd;
            r_h0_v        <= w_issue;
            r_h0_rd       <= w_rd;
            r_issue_valid <= w_issue;
            if (w_issue) begin
                r_func <= w_func;
                r_rd   <= w_rd;
                r_rs1  <= w_rs1;
                r_rs2  <= w_rs2;
                r_addr <= w_addr;
            end
            if (w_func == F_JMP) begin
                r_pc <= w_addr;
            end else if (w_func == F_HALT) begin
                r_state  <= S_HALTED;
                r_halted <= 1'b1;
            end else if (!w_stall) begin
                r_pc <= r_pc + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: directed and randomized checks of the fetch/decode stage
module tb_instr_fetch_decode;
    logic        clk1, rst, start, prog_we;
    logic [7:0]  prog_addr;
    logic [23:0] prog_data;
    logic [3:0]  func, rd, rs1, rs2;
    logic [7:0]  addr, pc;
    logic        issue_valid, halted;

    instr_fetch_decode #(.IMEM_DEPTH(256), .IW(24)) dut (
        .clk1(clk1), .rst(rst), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .func(func), .rd(rd), .rs1(rs1), .rs2(rs2), .addr(addr),
        .issue_valid(issue_valid), .pc(pc), .halted(halted)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    int n_checks;
    int n_err;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: program image, run mode, and per-register cycle of last issue
    logic [23:0] mm [256];
    int          m_mode;
    logic [7:0]  m_pc;
    logic [15:0] m_fields;
    logic [7:0]  m_addr;
    bit          m_valid, m_stall, m_halted, m_live;
    int          cyc;
    int          last_wr [16];

    initial forever begin
        logic [23:0] w;
        bit raw;
        @(posedge clk1);
        cyc++;
        m_live  = 1'b1;
        m_stall = 1'b0;
        m_valid = 1'b0;
        if (rst) begin
            m_mode = 0; m_pc = 8'd0; m_fields = 16'd0; m_addr = 8'd0; m_halted = 1'b0;
            foreach (last_wr[i]) last_wr[i] = -100;
        end else if (m_mode != 1) begin
            if (prog_we) mm[prog_addr] = prog_data;
            if (start) begin
                m_mode = 1; m_pc = 8'd0; m_halted = 1'b0;
                foreach (last_wr[i]) last_wr[i] = -100;
            end
        end else begin
            w = mm[m_pc];
            raw = (w[23:20] < 4'd12) &&
                  ((cyc - last_wr[w[15:12]] <= 2) || (cyc - last_wr[w[11:8]] <= 2));
            m_stall = raw;
            if (w[23:20] < 4'd12 && !raw) begin
                m_valid = 1'b1;
                last_wr[w[19:16]] = cyc;
                m_fields = w[23:8];
                m_addr = w[7:0];
                m_pc = m_pc + 8'd1;
            end else if (w[23:20] == 4'd13) begin
                m_pc = w[7:0];
            end else if (w[23:20] == 4'd14) begin
                m_mode = 2;
                m_halted = 1'b1;
            end else if (!raw) begin
                m_pc = m_pc + 8'd1;
            end
        end
    end

    initial forever begin
        @(negedge clk1);
        if (m_live) begin
            chk("pc", int'(pc), int'(m_pc));
            chk("issue_valid", int'(issue_valid), int'(m_valid));
            chk("halted", int'(halted), int'(m_halted));
            if (m_valid || m_stall) begin
                chk("fields", int'({func, rd, rs1, rs2}), int'(m_fields));
                chk("addr", int'(addr), int'(m_addr));
            end
        end
    end

    function automatic logic [23:0] enc(int f, int d, int s1, int s2, int a);
        return {f[3:0], d[3:0], s1[3:0], s2[3:0], a[7:0]};
    endfunction

    function automatic logic [23:0] rand_word(int i);
        int r;
        if (i == 31) return enc(14, 0, 0, 0, 0);
        r = $urandom_range(0, 99);
        if (r < 70) return enc($urandom_range(0, 11), $urandom_range(0, 3), $urandom_range(0, 3),
                               $urandom_range(0, 3), $urandom_range(0, 255));
        if (r < 80) return enc($urandom_range(0, 1) == 1 ? 15 : 12, $urandom_range(0, 15),
                               $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
        if (r < 90) return enc(13, $urandom_range(0, 15), 0, 0, $urandom_range(0, 30));
        return enc(14, 0, 0, 0, 0);
    endfunction

    task automatic cycle();
        @(negedge clk1);
    endtask

    task automatic prog(input int a, input logic [23:0] d);
        prog_we = 1'b1; prog_addr = a[7:0]; prog_data = d;
        cycle();
        prog_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    function automatic int obs();
        return int'({issue_valid, func, rd, rs1, rs2});
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = 8'd0; prog_data = 24'd0;
        cycle(); cycle();
        chk("rst_pc", int'(pc), 0);
        chk("rst_out", int'({issue_valid, halted, func, rd, rs1, rs2, addr}), 0);
        rst = 1'b0;

        prog(0, enc(0, 1, 2, 3, 0)); prog(1, enc(1, 4, 5, 6, 0));
        prog(2, enc(5, 7, 8, 9, 0)); prog(3, enc(14, 0, 0, 0, 0));
        go();
        chk("ind_pc0", int'(pc), 0);
        cycle(); chk("ind_add", obs(), 'h10123);
        cycle(); chk("ind_sub", obs(), 'h11456);
        cycle(); chk("ind_and", obs(), 'h15789);
        cycle(); chk("ind_halt", int'({halted, issue_valid}), 2); chk("ind_pc_hold", int'(pc), 3);

        prog(1, enc(0, 4, 1, 5, 0)); prog(2, enc(14, 0, 0, 0, 0));
        go();
        cycle(); chk("d1_first", obs(), 'h10123);
        cycle(); chk("d1_bub1", int'({issue_valid, pc}), 1);
        cycle(); chk("d1_bub2", int'({issue_valid, pc}), 1);
        cycle(); chk("d1_second", obs(), 'h10415);
        cycle(); chk("d1_halt", int'(halted), 1);

        prog(1, enc(3, 6, 7, 8, 0)); prog(2, enc(4, 9, 10, 1, 0)); prog(3, enc(14, 0, 0, 0, 0));
        go();
        cycle(); chk("d2_add", obs(), 'h10123);
        cycle(); chk("d2_or", obs(), 'h13678);
        cycle(); chk("d2_bub", int'({issue_valid, pc}), 2);
        cycle(); chk("d2_xor", obs(), 'h149a1);
        cycle(); chk("d2_halt", int'(halted), 1);

        prog(0, enc(13, 0, 0, 0, 'h10)); prog('h10, enc(0, 2, 3, 4, 0)); prog('h11, enc(14, 0, 0, 0, 0));
        go();
        cycle(); chk("jmp_bub", int'({issue_valid, pc}), 'h10);
        cycle(); chk("jmp_target", obs(), 'h10234);
        cycle(); chk("jmp_halt", int'(halted), 1);

        prog(0, enc(0, 1, 2, 3, 0)); prog(1, enc(12, 0, 0, 0, 0));
        prog(2, enc(12, 0, 0, 0, 0)); prog(3, enc(12, 0, 0, 0, 0)); prog(4, enc(14, 0, 0, 0, 0));
        go();
        start = 1'b1; prog_we = 1'b1; prog_addr = 8'd0; prog_data = enc(14, 0, 0, 0, 0);
        cycle();
        start = 1'b0; prog_we = 1'b0;
        chk("prot_issue", obs(), 'h10123);
        chk("prot_pc1", int'(pc), 1);
        cycle(); chk("prot_start_ignored", int'(pc), 2);
        repeat (3) cycle();
        chk("prot_halt", int'({halted, pc}), 'h104);
        go();
        cycle(); chk("prot_readback", obs(), 'h10123);
        repeat (4) cycle();
        chk("prot_halt2", int'(halted), 1);

        prog(0, enc(13, 0, 0, 0, 'hfe)); prog('hfe, enc(12, 0, 0, 0, 0)); prog('hff, enc(15, 1, 2, 3, 0));
        go();
        chk("wrap_pc0", int'(pc), 0);
        cycle(); chk("wrap_fe", int'(pc), 'hfe);
        cycle(); chk("wrap_ff", int'(pc), 'hff);
        cycle(); chk("wrap_00", int'({issue_valid, pc}), 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst", int'({issue_valid, halted, func, rd, rs1, rs2, addr, pc}), 0);
        rst = 1'b1; start = 1'b1;
        cycle();
        rst = 1'b0; start = 1'b0;
        cycle(); cycle();
        chk("rst_wins", int'(pc), 0);

        prog(1, enc(14, 0, 0, 0, 0));
        prog_we = 1'b1; prog_addr = 8'd0; prog_data = enc(0, 7, 8, 9, 0); start = 1'b1;
        cycle();
        prog_we = 1'b0; start = 1'b0;
        chk("wstart_pc", int'(pc), 0);
        cycle(); chk("wstart_issue", obs(), 'h10789);
        cycle(); chk("wstart_halt", int'(halted), 1);

        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 32; i++) prog(i, rand_word(i));
            go();
            for (int c = 0; c < 300 && m_mode == 1; c++) begin
                start = $urandom_range(0, 9) == 0;
                rst = $urandom_range(0, 149) == 0;
                prog_we = !rst && $urandom_range(0, 7) == 0;
                prog_addr = 8'($urandom_range(0, 31));
                prog_data = 24'($urandom);
                cycle();
            end
            start = 1'b0; prog_we = 1'b0; rst = 1'b0;
            if (m_mode == 1) begin
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
